// File: rtl/accelerator_scalar_fixed_alu.sv
// Signed fixed-point (Q-format) scalar ALU: add, sub, shift-add multiply, restoring divide.
// Define ACCELERATOR_FIXED_SATURATE_EN to clamp overflowing results instead of wrapping.
module accelerator_scalar_fixed_alu #(
    parameter int DATA_SIZE     = 64,
    parameter int FRACTION_SIZE = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic [1:0]           OPERATION,
    input  logic [DATA_SIZE-1:0] DATA_A_IN,
    input  logic [DATA_SIZE-1:0] DATA_B_IN,
    output logic                 READY,
    output logic [DATA_SIZE-1:0] DATA_OUT,
    output logic                 OVERFLOW_OUT
);

    localparam int N  = DATA_SIZE;
    localparam int F  = FRACTION_SIZE;
    localparam int PW = 2 * N;
    localparam int QW = N + F;
    localparam int CW = $clog2(QW + 1);

    localparam logic [CW-1:0] MUL_ITERS = CW'(N);
    localparam logic [CW-1:0] DIV_ITERS = CW'(QW);

    localparam logic [N-1:0] MAX_POS = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

    localparam logic [PW-1:0] POS_LIMIT = PW'(MAX_POS);
    localparam logic [PW-1:0] NEG_LIMIT = PW'(MIN_NEG);

    typedef enum logic [2:0] {
        IDLE,
        ADD,
        MUL,
        DIV,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic          sub_q;
    logic [N-1:0]  a_q;
    logic [N-1:0]  b_q;
    logic [N-1:0]  b_mag;
    logic          res_neg_q;
    logic          a_neg_q;
    logic [PW-1:0] acc;
    logic [PW-1:0] mcand;
    logic [N-1:0]  mplier;
    logic [N-1:0]  rem;
    logic [QW-1:0] dq;
    logic [CW-1:0] cnt;

    logic [N-1:0]  in_a_mag;
    logic [N-1:0]  in_b_mag;
    logic          mul_last;
    logic          div_zero;
    logic          div_last;
    logic          finish;

    logic [N:0]    rem_shift;
    logic [N-1:0]  rem_sub;
    logic          q_bit;
    logic [N:0]    sum;

    logic [PW-1:0] mag;
    logic [N-1:0]  mag_lo;
    logic [N-1:0]  wrap_val;
    logic [N-1:0]  res_val;
    logic          sat_neg;
    logic          res_ovf;

    // Magnitudes fit DATA_SIZE unsigned bits, including the most negative operand.
    assign in_a_mag = DATA_A_IN[N-1] ? (~DATA_A_IN + N'(1)) : DATA_A_IN;
    assign in_b_mag = DATA_B_IN[N-1] ? (~DATA_B_IN + N'(1)) : DATA_B_IN;

    assign mul_last = (cnt == MUL_ITERS);
    assign div_zero = (b_mag == '0);
    assign div_last = div_zero || (cnt == DIV_ITERS);
    assign finish   = (state == ADD)
                   || (state == MUL && mul_last)
                   || (state == DIV && div_last);

    // One restoring-division step; a successful subtract always fits DATA_SIZE bits.
    assign rem_shift = {rem, dq[QW-1]};
    assign q_bit     = (rem_shift >= {1'b0, b_mag});
    assign rem_sub   = rem_shift[N-1:0] - b_mag;

    // Add/sub carried at DATA_SIZE+1 bits so overflow is exact.
    assign sum = sub_q ? ({a_q[N-1], a_q} - {b_q[N-1], b_q})
                       : ({a_q[N-1], a_q} + {b_q[N-1], b_q});

    // Final result, overflow flag and wrap/saturate selection for the active operation.
    always_comb begin
        mag      = '0;
        mag_lo   = '0;
        wrap_val = '0;
        res_val  = '0;
        sat_neg  = 1'b0;
        res_ovf  = 1'b0;
        if (state == ADD) begin
            wrap_val = sum[N-1:0];
            sat_neg  = sum[N];
            res_ovf  = sum[N] ^ sum[N-1];
        end else begin
            mag      = (state == DIV) ? PW'(dq) : (acc >> F);
            mag_lo   = mag[N-1:0];
            wrap_val = res_neg_q ? (~mag_lo + N'(1)) : mag_lo;
            sat_neg  = res_neg_q;
            res_ovf  = mag > (res_neg_q ? NEG_LIMIT : POS_LIMIT);
        end
`ifdef ACCELERATOR_FIXED_SATURATE_EN
        res_val = res_ovf ? (sat_neg ? MIN_NEG : MAX_POS) : wrap_val;
`else
        res_val = wrap_val;
`endif
        if (state == DIV && div_zero) begin
            res_val = a_neg_q ? MIN_NEG : MAX_POS;
            res_ovf = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection; START only matters in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (START) begin
                    case (OPERATION)
                        2'b10:   state_next = MUL;
                        2'b11:   state_next = DIV;
                        default: state_next = ADD;
                    endcase
                end
            end
            ADD:     state_next = DONE;
            MUL:     if (mul_last) state_next = DONE;
            DIV:     if (div_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sub_q        <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            b_mag        <= '0;
            res_neg_q    <= 1'b0;
            a_neg_q      <= 1'b0;
            acc          <= '0;
            mcand        <= '0;
            mplier       <= '0;
            rem          <= '0;
            dq           <= '0;
            cnt          <= '0;
            READY        <= 1'b0;
            DATA_OUT     <= '0;
            OVERFLOW_OUT <= 1'b0;
        end else begin
            READY <= finish;
            case (state)
                IDLE: begin
                    if (START) begin
                        sub_q     <= OPERATION[0];
                        a_q       <= DATA_A_IN;
                        b_q       <= DATA_B_IN;
                        b_mag     <= in_b_mag;
                        res_neg_q <= DATA_A_IN[N-1] ^ DATA_B_IN[N-1];
                        a_neg_q   <= DATA_A_IN[N-1];
                        acc       <= '0;
                        mcand     <= PW'(in_a_mag);
                        mplier    <= in_b_mag;
                        rem       <= '0;
                        dq        <= QW'(in_a_mag) << F;
                        cnt       <= '0;
                    end
                end
                MUL: begin
                    if (!mul_last) begin
                        acc    <= acc + (mplier[0] ? mcand : '0);
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + CW'(1);
                    end
                end
                DIV: begin
                    if (!div_last) begin
                        rem <= q_bit ? rem_sub : rem_shift[N-1:0];
                        dq  <= {dq[QW-2:0], q_bit};
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
            if (finish) begin
                DATA_OUT     <= res_val;
                OVERFLOW_OUT <= res_ovf;
            end
        end
    end

endmodule

// File: tb/tb_accelerator_scalar_fixed_alu.sv
// Directed bench for accelerator_scalar_fixed_alu at DATA_SIZE=16, FRACTION_SIZE=8.
// Expected values are hand-computed Q8.8 results; both saturate and wrap builds covered.
module tb_accelerator_scalar_fixed_alu;

    logic        CLK;
    logic        RST;
    logic        START;
    logic [1:0]  OPERATION;
    logic [15:0] DATA_A_IN;
    logic [15:0] DATA_B_IN;
    logic        READY;
    logic [15:0] DATA_OUT;
    logic        OVERFLOW_OUT;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef ACCELERATOR_FIXED_SATURATE_EN
    localparam logic [15:0] ADD_OVF_EXP  = 16'h7FFF;
    localparam logic [15:0] MUL_OVF_EXP  = 16'h7FFF;
    localparam logic [15:0] DIV_OVF_EXP  = 16'h7FFF;
    localparam logic [15:0] SUB_OVF_EXP  = 16'h8000;
`else
    localparam logic [15:0] ADD_OVF_EXP  = 16'h8100;
    localparam logic [15:0] MUL_OVF_EXP  = 16'h0000;
    localparam logic [15:0] DIV_OVF_EXP  = 16'h8000;
    localparam logic [15:0] SUB_OVF_EXP  = 16'h7F00;
`endif

    accelerator_scalar_fixed_alu #(
        .DATA_SIZE    (16),
        .FRACTION_SIZE(8)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .START       (START),
        .OPERATION   (OPERATION),
        .DATA_A_IN   (DATA_A_IN),
        .DATA_B_IN   (DATA_B_IN),
        .READY       (READY),
        .DATA_OUT    (DATA_OUT),
        .OVERFLOW_OUT(OVERFLOW_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: plain; 1: re-pulse START mid-multiply; 2: START during DONE.
    task automatic run_op(input logic [1:0] op, input logic [15:0] a,
                          input logic [15:0] b, input int mode,
                          output int lat);
        @(negedge CLK);
        OPERATION = op;
        DATA_A_IN = a;
        DATA_B_IN = b;
        START     = 1'b1;
        lat       = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge CLK);
            #1;
            START = 1'b0;
            if (mode == 1 && n == 5) begin
                START     = 1'b1;
                OPERATION = 2'b00;
                DATA_A_IN = 16'h1234;
                DATA_B_IN = 16'h1111;
            end
            if (READY) begin
                lat = n;
                break;
            end
        end
        if (mode == 2) begin
            START     = 1'b1;
            OPERATION = 2'b00;
            DATA_A_IN = 16'h0100;
            DATA_B_IN = 16'h0100;
        end
        @(posedge CLK);
        #1;
        START = 1'b0;
        check("ready_drop", 64'(READY), 64'(0));
    endtask

    task automatic quiet(input string tag, input int cycles);
        int hits = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge CLK);
            #1;
            if (READY) hits++;
        end
        check(tag, 64'(hits), 64'(0));
    endtask

    task automatic vec(input string tag, input logic [1:0] op,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] exp_out, input logic exp_ovf,
                       input int exp_lat);
        int lat;
        run_op(op, a, b, 0, lat);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_out"}, 64'(DATA_OUT), 64'(exp_out));
        check({tag, "_ovf"}, 64'(OVERFLOW_OUT), 64'(exp_ovf));
    endtask

    initial begin
        int lat;
        RST       = 1'b1;
        START     = 1'b0;
        OPERATION = 2'b00;
        DATA_A_IN = '0;
        DATA_B_IN = '0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_ready", 64'(READY), 64'(0));
        check("rst_out", 64'(DATA_OUT), 64'(0));
        check("rst_ovf", 64'(OVERFLOW_OUT), 64'(0));
        RST = 1'b0;

        vec("mul_1p5x2",   2'b10, 16'h0180, 16'h0200, 16'h0300, 1'b0, 18);
        vec("div_3_m2",    2'b11, 16'h0300, 16'hFE00, 16'hFE80, 1'b0, 26);
        vec("add_ovf",     2'b00, 16'h7F00, 16'h0200, ADD_OVF_EXP, 1'b1, 2);
        vec("div_zero",    2'b11, 16'h0100, 16'h0000, 16'h7FFF, 1'b1, 2);
        vec("div_zero_n",  2'b11, 16'hFF00, 16'h0000, 16'h8000, 1'b1, 2);
        vec("mul_neg",     2'b10, 16'hFF00, 16'h0280, 16'hFD80, 1'b0, 18);
        vec("mul_ovf",     2'b10, 16'h4000, 16'h0400, MUL_OVF_EXP, 1'b1, 18);
        vec("mul_minneg",  2'b10, 16'h8000, 16'h0100, 16'h8000, 1'b0, 18);
        vec("mul_tiny",    2'b10, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 18);
        vec("div_minneg",  2'b11, 16'h8000, 16'hFF00, DIV_OVF_EXP, 1'b1, 26);
        vec("div_third",   2'b11, 16'h0100, 16'h0300, 16'h0055, 1'b0, 26);
        vec("div_mthird",  2'b11, 16'hFF00, 16'h0300, 16'hFFAB, 1'b0, 26);
        vec("add_zero",    2'b00, 16'h0100, 16'hFF00, 16'h0000, 1'b0, 2);
        vec("sub_ovf",     2'b01, 16'h8000, 16'h0100, SUB_OVF_EXP, 1'b1, 2);

        run_op(2'b10, 16'h0180, 16'h0200, 1, lat);
        check("mid_start_lat", 64'(lat), 64'(18));
        check("mid_start_out", 64'(DATA_OUT), 64'(16'h0300));
        check("mid_start_ovf", 64'(OVERFLOW_OUT), 64'(0));
        quiet("mid_start_quiet", 25);

        run_op(2'b10, 16'h0180, 16'h0200, 2, lat);
        check("done_start_lat", 64'(lat), 64'(18));
        quiet("done_start_quiet", 6);
        check("done_start_out", 64'(DATA_OUT), 64'(16'h0300));

        @(negedge CLK);
        OPERATION = 2'b10;
        DATA_A_IN = 16'h0180;
        DATA_B_IN = 16'h0200;
        START     = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            @(posedge CLK);
            #1;
            START = 1'b0;
        end
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        check("abort_ready", 64'(READY), 64'(0));
        check("abort_out", 64'(DATA_OUT), 64'(0));
        check("abort_ovf", 64'(OVERFLOW_OUT), 64'(0));
        quiet("abort_quiet", 25);

        vec("sub_after",   2'b01, 16'h0100, 16'h0300, 16'hFE00, 1'b0, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/accelerator_scalar_fixed_alu.md
ACCELERATOR_SCALAR_FIXED_ALU -- requirements
Module: accelerator_scalar_fixed_alu

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 64, operand/result width (signed two's complement).
REQ-002 SHALL have parameter FRACTION_SIZE, default 32, fractional bits of Q-format; 0 <= FRACTION_SIZE < DATA_SIZE.
REQ-003 SHALL have port CLK  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port START  input  1  operation request, sampled only in IDLE.
REQ-006 SHALL have port OPERATION  input  2  00 add, 01 subtract, 10 multiply, 11 divide.
REQ-007 SHALL have ports DATA_A_IN, DATA_B_IN  input  DATA_SIZE  operands (A op B).
REQ-008 SHALL have port READY  output  1  one-cycle pulse, result valid.
REQ-009 SHALL have port DATA_OUT  output  DATA_SIZE  result, held until next READY or reset.
REQ-010 SHALL have port OVERFLOW_OUT  output  1  result not representable / divide by zero; updated with READY.

Function
REQ-011 SHALL implement FSM states IDLE, ADD, MUL, DIV, DONE.
REQ-012 SHALL, in IDLE with START=1, latch OPERATION, DATA_A_IN, DATA_B_IN and move to ADD (00/01), MUL (10) or DIV (11).
REQ-013 SHALL ignore START and input changes in every state other than IDLE.
REQ-014 SHALL compute add/sub in ADD in one cycle at DATA_SIZE+1 bits, then DONE; READY high on cycle 2 after START cycle.
REQ-015 SHALL compute multiply on operand magnitudes by shift-add, one bit per cycle, DATA_SIZE iterations; READY on cycle DATA_SIZE+2.
REQ-016 SHALL form multiply result as (|A|*|B|) >> FRACTION_SIZE (truncation toward zero), negated if operand signs differ.
REQ-017 SHALL compute divide by restoring division of (|A| << FRACTION_SIZE) by |B|, one quotient bit per cycle, DATA_SIZE+FRACTION_SIZE iterations; READY on cycle DATA_SIZE+FRACTION_SIZE+2.
REQ-018 SHALL negate quotient if operand signs differ; remainder discarded (truncation toward zero).
REQ-019 SHALL, on divide with DATA_B_IN=0, skip iteration, go DIV->DONE next cycle (READY on cycle 2), DATA_OUT = max positive if A>=0 else min negative, OVERFLOW_OUT=1, regardless of configuration.
REQ-020 SHALL assert OVERFLOW_OUT when the full-precision signed result lies outside [-2^(DATA_SIZE-1), 2^(DATA_SIZE-1)-1].
REQ-021 SHALL hold READY high exactly one cycle in DONE, then return to IDLE; START in the DONE cycle is ignored, earliest accepted START is cycle after DONE.
REQ-022 SHALL handle the most negative operand correctly (magnitude held in DATA_SIZE-bit unsigned).

Reset
REQ-023 SHALL, with RST=1 at a clock edge, enter IDLE and clear READY, DATA_OUT, OVERFLOW_OUT and all iteration counters/accumulators to 0.
REQ-024 SHALL abort any in-flight operation on RST without producing READY; RST has priority over START.

Configuration
REQ-025 SHALL, with macro ACCELERATOR_FIXED_SATURATE_EN defined, clamp overflowing results to 2^(DATA_SIZE-1)-1 or -2^(DATA_SIZE-1) by sign of full-precision result.
REQ-026 SHALL, without ACCELERATOR_FIXED_SATURATE_EN, output the low DATA_SIZE bits (wrap); OVERFLOW_OUT behaviour identical in both builds.

Verification (DATA_SIZE=16, FRACTION_SIZE=8)
REQ-027 SHALL check multiply 0x0180 * 0x0200 (1.5*2.0) -> DATA_OUT=0x0300, OVERFLOW_OUT=0, READY exactly 18 cycles after START.
REQ-028 SHALL check divide 0x0300 / 0xFE00 (3.0/-2.0) -> DATA_OUT=0xFE80, READY exactly 26 cycles after START.
REQ-029 SHALL check add 0x7F00 + 0x0200 -> OVERFLOW_OUT=1, DATA_OUT=0x7FFF with SATURATE_EN, 0x8100 without.
REQ-030 SHALL check divide 0x0100 / 0x0000 -> DATA_OUT=0x7FFF, OVERFLOW_OUT=1, READY 2 cycles after START.
REQ-031 SHALL check START pulsed with new operands during multiply -> ignored, first result unchanged, single READY.
REQ-032 SHALL check RST asserted at cycle 5 of multiply -> no READY, outputs 0; subsequent subtract 0x0100 - 0x0300 -> 0xFE00.
